// File: rtl/huff_pkg.sv
// Shared Huffman widths, types and decoder state encoding.
// Used by both huff_encoder and huff_decoder.
`ifndef MAX_CHAR_COUNT
`define MAX_CHAR_COUNT 5
`endif
`ifndef MAX_STRING_LENGTH
`define MAX_STRING_LENGTH 8
`endif

package huff_pkg;
    localparam int CODE_W = `MAX_CHAR_COUNT;
    localparam int LEN_W  = $clog2(`MAX_STRING_LENGTH + 1);

    typedef logic [7:0]        char_t;
    typedef logic [CODE_W-1:0] code_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DECODE,
        EMIT,
        DONE,
        ERROR
    } dec_state_t;

    localparam char_t CHAR_UNUSED = 8'h00;
endpackage

// File: rtl/huff_code_match.sv
// Combinational lookup of the partial code (acc, len) against the latched table.
// The scan runs from the top entry down, so the lowest matching index wins.
module huff_code_match
    import huff_pkg::*;
#(
    parameter int N  = `MAX_CHAR_COUNT,
    parameter int AW = $clog2(N + 1),
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0][7:0]   char_tbl,
    input  logic [N-1:0][N-1:0] val_tbl,
    input  logic [N-1:0][N-1:0] mask_tbl,
    input  logic [N-1:0]        acc,
    input  logic [AW-1:0]       len,
    output logic                hit,
    output logic [IW-1:0]       hit_idx
);

    logic [N-1:0][AW-1:0] code_len;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            code_len[i] = '0;
            for (int b = 0; b < N; b++) begin
                code_len[i] = code_len[i] + AW'(mask_tbl[i][b]);
            end
        end
    end

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if ((char_tbl[i] != CHAR_UNUSED) && (code_len[i] == len) &&
                ((acc & mask_tbl[i]) == (val_tbl[i] & mask_tbl[i]))) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/huff_decoder.sv
// Huffman receive path: latches the code table, shifts in code bits MSB first,
// and emits decoded symbols while assembling them into an encoder-compatible string.
module huff_decoder
    import huff_pkg::*;
#(
    parameter int MAX_CHAR_COUNT    = `MAX_CHAR_COUNT,
    parameter int MAX_STRING_LENGTH = `MAX_STRING_LENGTH
) (
    input  logic                                             clk,
    input  logic                                             reset,
    input  logic                                             start,
    input  logic [MAX_CHAR_COUNT-1:0][7:0]                   character,
    input  logic [MAX_CHAR_COUNT-1:0][MAX_CHAR_COUNT-1:0]    encoded_value,
    input  logic [MAX_CHAR_COUNT-1:0][MAX_CHAR_COUNT-1:0]    encoded_mask,
    input  logic [$clog2(MAX_STRING_LENGTH+1)-1:0]           sym_count,
    input  logic                                             bit_in,
    input  logic                                             bit_valid,
    output logic                                             bit_ready,
    output logic [7:0]                                       char_out,
    output logic                                             char_valid,
    input  logic                                             char_ready,
    output logic [MAX_STRING_LENGTH-1:0][7:0]                data_out,
    output logic                                             done,
    output logic                                             error
);

    localparam int CW = MAX_CHAR_COUNT;
    localparam int LW = $clog2(MAX_STRING_LENGTH + 1);
    localparam int AW = $clog2(CW + 1);
    localparam int IW = (CW > 1) ? $clog2(CW) : 1;

    dec_state_t state_q, state_d;

    logic [CW-1:0][7:0]    char_tbl_q, char_tbl_d;
    logic [CW-1:0][CW-1:0] val_tbl_q,  val_tbl_d;
    logic [CW-1:0][CW-1:0] mask_tbl_q, mask_tbl_d;
    logic [LW-1:0]         sym_count_q, sym_count_d;
    logic                  single_q, single_d;
    logic [CW-1:0]         acc_q, acc_d;
    logic [AW-1:0]         acc_len_q, acc_len_d;
    logic [LW-1:0]         pos_q, pos_d;
    char_t                 char_out_q, char_out_d;
    logic                  char_valid_q, char_valid_d;
    logic [MAX_STRING_LENGTH-1:0][7:0] data_out_q, data_out_d;

    logic [CW-1:0] acc_nxt;
    logic [AW-1:0] len_nxt;
    logic          hit;
    logic [IW-1:0] hit_idx;
    logic [AW-1:0] used_cnt;
    logic          zero_mask_used;
    logic [IW-1:0] zero_idx;
    logic          single_mode;
    logic [LW-1:0] wr_idx;

    always_comb begin
        acc_nxt = {acc_q[CW-2:0], bit_in};
        len_nxt = acc_len_q + AW'(1);
        wr_idx  = sym_count_q - pos_q - LW'(1);
    end

    huff_code_match #(
        .N  (CW),
        .AW (AW),
        .IW (IW)
    ) u_match (
        .char_tbl (char_tbl_q),
        .val_tbl  (val_tbl_q),
        .mask_tbl (mask_tbl_q),
        .acc      (acc_nxt),
        .len      (len_nxt),
        .hit      (hit),
        .hit_idx  (hit_idx)
    );

    // A table whose only used entry has an empty code means the string is one
    // repeated symbol, emitted without consuming any bits.
    always_comb begin
        used_cnt       = '0;
        zero_mask_used = 1'b0;
        zero_idx       = '0;
        for (int i = 0; i < CW; i++) begin
            if (char_tbl_q[i] != CHAR_UNUSED) begin
                used_cnt = used_cnt + AW'(1);
                if (mask_tbl_q[i] == '0) begin
                    zero_mask_used = 1'b1;
                    zero_idx       = IW'(i);
                end
            end
        end
        single_mode = (used_cnt == AW'(1)) && zero_mask_used;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        char_tbl_d   = char_tbl_q;
        val_tbl_d    = val_tbl_q;
        mask_tbl_d   = mask_tbl_q;
        sym_count_d  = sym_count_q;
        single_d     = single_q;
        acc_d        = acc_q;
        acc_len_d    = acc_len_q;
        pos_d        = pos_q;
        char_out_d   = char_out_q;
        char_valid_d = char_valid_q;
        data_out_d   = data_out_q;

        case (state_q)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_d      = LOAD;
                    char_tbl_d   = character;
                    val_tbl_d    = encoded_value;
                    mask_tbl_d   = encoded_mask;
                    sym_count_d  = sym_count;
                    single_d     = 1'b0;
                    acc_d        = '0;
                    acc_len_d    = '0;
                    pos_d        = '0;
                    char_valid_d = 1'b0;
                    data_out_d   = '0;
                end
            end
            LOAD: begin
                if (sym_count_q == '0) begin
                    state_d = DONE;
                end else if (single_mode) begin
                    state_d      = EMIT;
                    single_d     = 1'b1;
                    char_out_d   = char_tbl_q[zero_idx];
                    char_valid_d = 1'b1;
                end else begin
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (bit_valid) begin
                    if (hit) begin
                        state_d      = EMIT;
                        char_out_d   = char_tbl_q[hit_idx];
                        char_valid_d = 1'b1;
                        acc_d        = '0;
                        acc_len_d    = '0;
                    end else if (len_nxt == AW'(CW)) begin
                        state_d = ERROR;
                    end else begin
                        acc_d     = acc_nxt;
                        acc_len_d = len_nxt;
                    end
                end
            end
            EMIT: begin
                if (char_ready) begin
                    // First symbol lands at the highest used byte, last at byte 0.
                    for (int i = 0; i < MAX_STRING_LENGTH; i++) begin
                        if (LW'(i) == wr_idx) begin
                            data_out_d[i] = char_out_q;
                        end
                    end
                    pos_d = pos_q + LW'(1);
                    if (pos_d == sym_count_q) begin
                        state_d      = DONE;
                        char_valid_d = 1'b0;
                    end else if (!single_q) begin
                        state_d      = DECODE;
                        char_valid_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            char_tbl_q   <= '0;
            val_tbl_q    <= '0;
            mask_tbl_q   <= '0;
            sym_count_q  <= '0;
            single_q     <= 1'b0;
            acc_q        <= '0;
            acc_len_q    <= '0;
            pos_q        <= '0;
            char_out_q   <= '0;
            char_valid_q <= 1'b0;
            data_out_q   <= '0;
        end else begin
            char_tbl_q   <= char_tbl_d;
            val_tbl_q    <= val_tbl_d;
            mask_tbl_q   <= mask_tbl_d;
            sym_count_q  <= sym_count_d;
            single_q     <= single_d;
            acc_q        <= acc_d;
            acc_len_q    <= acc_len_d;
            pos_q        <= pos_d;
            char_out_q   <= char_out_d;
            char_valid_q <= char_valid_d;
            data_out_q   <= data_out_d;
        end
    end

    always_comb begin
        bit_ready  = (state_q == DECODE);
        done       = (state_q == DONE);
        error      = (state_q == ERROR);
        char_out   = char_out_q;
        char_valid = char_valid_q;
        data_out   = data_out_q;
    end

endmodule

// File: tb/tb_huff_decoder.sv
// Scoreboard bench for huff_decoder: directed cases plus random prefix-free tables.
module tb_huff_decoder;
    localparam int N   = 5;
    localparam int MSL = 8;
    localparam int CW  = 5;
    localparam int LW  = 4;

    logic clk = 1'b0;
    logic reset, start, bit_in, bit_valid, bit_ready;
    logic char_valid, char_ready, done, error;
    logic [N-1:0][7:0]    character;
    logic [N-1:0][CW-1:0] encoded_value, encoded_mask;
    logic [LW-1:0]        sym_count;
    logic [7:0]           char_out;
    logic [MSL-1:0][7:0]  data_out;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic       bit_q[$];
    int ready_mode = 0;
    int bitrdy_hits = 0;
    logic [7:0] exp_c;

    huff_decoder #(.MAX_CHAR_COUNT(N), .MAX_STRING_LENGTH(MSL)) dut (
        .clk(clk), .reset(reset), .start(start), .character(character),
        .encoded_value(encoded_value), .encoded_mask(encoded_mask),
        .sym_count(sym_count), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_ready(bit_ready), .char_out(char_out), .char_valid(char_valid),
        .char_ready(char_ready), .data_out(data_out), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (ready_mode == 0) char_ready = 1'b1;
        else if (ready_mode == 1) char_ready = ($urandom_range(0, 3) != 0);
    end

    always @(negedge clk) begin
        if (bit_ready) bitrdy_hits++;
        if (!reset && char_valid && char_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_char got %h want none", char_out);
            end else begin
                exp_c = exp_q.pop_front();
                chk("char_out", 64'(char_out), 64'(exp_c));
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic send_bit(input logic b, input bit bubble);
        bit got = 0;
        if (bubble && $urandom_range(0, 2) == 0) begin
            bit_valid = 1'b0;
            @(posedge clk); #1;
        end
        bit_in = b;
        bit_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (bit_ready) begin got = 1; break; end
        end
        chk("bit_accept", 64'(got), 64'd1);
        @(posedge clk); #1;
        bit_valid = 1'b0;
    endtask

    task automatic wait_end();
        bit got = 0;
        for (int t = 0; t < 500; t++) begin
            @(negedge clk);
            if (done || error) begin got = 1; break; end
        end
        chk("end_timeout", 64'(got), 64'd1);
    endtask

    task automatic run_case(input string name, input logic [63:0] exp_data,
                            input bit bubble, input bit single);
        bitrdy_hits = 0;
        pulse_start();
        while (bit_q.size() > 0) send_bit(bit_q.pop_front(), bubble);
        wait_end();
        chk({name, "_done"}, 64'(done), 64'd1);
        chk({name, "_error"}, 64'(error), 64'd0);
        chk({name, "_data"}, data_out, exp_data);
        chk({name, "_leftover"}, 64'(exp_q.size()), 64'd0);
        if (single) chk({name, "_no_bit_ready"}, 64'(bitrdy_hits), 64'd0);
    endtask

    task automatic setup_anu();
        character = '0; encoded_value = '0; encoded_mask = '0;
        character[0] = "a"; encoded_value[0] = 5'b10; encoded_mask[0] = 5'b11;
        character[1] = "n"; encoded_value[1] = 5'b0;  encoded_mask[1] = 5'b01;
        character[2] = "u"; encoded_value[2] = 5'b11; encoded_mask[2] = 5'b11;
        sym_count = 4'd3;
        exp_q.push_back("a"); exp_q.push_back("n"); exp_q.push_back("u");
        bit_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    endtask

    initial begin
        int lens[5];
        int codes[5];
        int slot[5];
        logic [7:0] chars[5];
        int nu, kraft, l, sc, k, tmp, p, j;
        logic [63:0] exp_data;

        reset = 1'b1; start = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;
        char_ready = 1'b1; character = '0; encoded_value = '0;
        encoded_mask = '0; sym_count = '0;
        #3;
        chk("rst_bit_ready", 64'(bit_ready), 64'd0);
        chk("rst_char_valid", 64'(char_valid), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        chk("rst_char_out", 64'(char_out), 64'd0);
        chk("rst_data_out", data_out, 64'd0);
        @(posedge clk); #1 reset = 1'b0;

        // Test 1: basic decode, then extra bits after done
        setup_anu();
        run_case("anu", 64'h616e75, 0, 0);
        bit_in = 1'b1; bit_valid = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_done_bit_ready", 64'(bit_ready), 64'd0);
        chk("post_done_done", 64'(done), 64'd1);
        bit_valid = 1'b0;

        // Test 2: single-symbol string
        character = '0; encoded_value = '0; encoded_mask = '0;
        character[0] = "a"; sym_count = 4'd3;
        repeat (3) exp_q.push_back("a");
        run_case("single", 64'h616161, 0, 1);

        // Test 3: backpressure on the first symbol
        ready_mode = 2; char_ready = 1'b0;
        setup_anu();
        pulse_start();
        fork
            while (bit_q.size() > 0) send_bit(bit_q.pop_front(), 0);
            begin
                bit got = 0;
                for (int t = 0; t < 100; t++) begin
                    @(negedge clk);
                    if (char_valid) begin got = 1; break; end
                end
                chk("bp_first_valid", 64'(got), 64'd1);
                for (int c = 0; c < 3; c++) begin
                    if (c > 0) @(negedge clk);
                    chk("bp_hold_char", 64'(char_out), 64'h61);
                    chk("bp_hold_bit_ready", 64'(bit_ready), 64'd0);
                end
                @(posedge clk); #1 char_ready = 1'b1;
            end
        join
        ready_mode = 0;
        wait_end();
        chk("bp_done", 64'(done), 64'd1);
        chk("bp_data", data_out, 64'h616e75);
        chk("bp_leftover", 64'(exp_q.size()), 64'd0);

        // Test 4: no code matches within CODE_W bits
        character = '0; encoded_value = '0; encoded_mask = '0;
        character[0] = "a"; encoded_value[0] = 5'b0;  encoded_mask[0] = 5'b01;
        character[1] = "b"; encoded_value[1] = 5'b10; encoded_mask[1] = 5'b11;
        sym_count = 4'd2;
        pulse_start();
        for (int i = 0; i < 5; i++) send_bit(1'b1, 0);
        chk("err_error", 64'(error), 64'd1);
        chk("err_bit_ready", 64'(bit_ready), 64'd0);
        chk("err_char_valid", 64'(char_valid), 64'd0);
        bit_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("err_sticky", 64'(error), 64'd1);
        chk("err_bits_refused", 64'(bit_ready), 64'd0);
        bit_valid = 1'b0;

        // Test 5: zero-length string, then clean re-decode
        sym_count = 4'd0;
        pulse_start();
        chk("zero_load_done", 64'(done), 64'd0);
        chk("zero_load_error", 64'(error), 64'd0);
        @(posedge clk); #1;
        chk("zero_done", 64'(done), 64'd1);
        chk("zero_data", data_out, 64'd0);
        setup_anu();
        run_case("redecode", 64'h616e75, 0, 0);

        // Test 6: async reset mid-decode
        setup_anu();
        pulse_start();
        send_bit(bit_q.pop_front(), 0);
        send_bit(bit_q.pop_front(), 0);
        reset = 1'b1;
        #1;
        chk("mid_rst_char_valid", 64'(char_valid), 64'd0);
        chk("mid_rst_char_out", 64'(char_out), 64'd0);
        chk("mid_rst_bit_ready", 64'(bit_ready), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        chk("mid_rst_data", data_out, 64'd0);
        exp_q.delete();
        bit_q.delete();
        @(posedge clk); #1 reset = 1'b0;
        setup_anu();
        run_case("after_rst", 64'h616e75, 0, 0);

        // Random prefix-free tables (canonical codes from random Kraft-valid lengths)
        ready_mode = 1;
        for (int it = 0; it < 40; it++) begin
            character = '0; encoded_value = '0; encoded_mask = '0;
            for (int i = 0; i < 5; i++) slot[i] = i;
            for (int i = 4; i > 0; i--) begin
                j = $urandom_range(0, i);
                tmp = slot[i]; slot[i] = slot[j]; slot[j] = tmp;
            end
            if ($urandom_range(0, 7) == 0) nu = 1;
            else nu = $urandom_range(2, 5);
            if (nu == 1) begin
                lens[0] = 0; codes[0] = 0;
            end else begin
                kraft = 0;
                for (int i = 0; i < nu; i++) begin
                    l = 5;
                    for (int t = 0; t < 8; t++) begin
                        tmp = $urandom_range(1, 5);
                        if (kraft + (32 >> tmp) + (nu - 1 - i) <= 32) begin l = tmp; break; end
                    end
                    lens[i] = l;
                    kraft += 32 >> l;
                end
                for (int a = 0; a < nu; a++)
                    for (int b = 0; b < nu - 1 - a; b++)
                        if (lens[b] > lens[b+1]) begin
                            tmp = lens[b]; lens[b] = lens[b+1]; lens[b+1] = tmp;
                        end
                codes[0] = 0;
                for (int i = 1; i < nu; i++)
                    codes[i] = (codes[i-1] + 1) << (lens[i] - lens[i-1]);
                p = $urandom_range(0, 31);
                for (int i = 0; i < nu; i++) codes[i] = codes[i] ^ (p >> (5 - lens[i]));
            end
            for (int i = 0; i < nu; i++) begin
                chars[i] = 8'h61 + 8'($urandom_range(0, 25));
                character[slot[i]]     = chars[i];
                encoded_value[slot[i]] = CW'(codes[i]);
                encoded_mask[slot[i]]  = CW'((1 << lens[i]) - 1);
            end
            sc = $urandom_range(1, 8);
            sym_count = LW'(sc);
            exp_data = '0;
            for (int s = 0; s < sc; s++) begin
                k = $urandom_range(0, nu - 1);
                exp_q.push_back(chars[k]);
                exp_data[(sc - 1 - s) * 8 +: 8] = chars[k];
                for (int b = lens[k] - 1; b >= 0; b--) bit_q.push_back(1'((codes[k] >> b) & 1));
            end
            run_case("rand", exp_data, 1, (nu == 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1);
    end
endmodule
